// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: builds the 11-bit serial frame and paces the
// load/shift strobes of the external transmit shift register at the
// programmed baud divisor.
module uart_tx_ctrl #(
  parameter int unsigned BAUD_W = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_start,
  input  logic [7:0]        tx_data,
  input  logic              eight,
  input  logic              pen,
  input  logic              ohel,
  input  logic [BAUD_W-1:0] baud_k,
  output logic              ld,
  output logic              sh,
  output logic [10:0]       frame,
  output logic              tx_rdy,
  output logic              done
);

  localparam int unsigned FRAME_W  = 11;
  localparam int unsigned BITCNT_W = 4;
  localparam logic [BITCNT_W-1:0] LAST_BIT = BITCNT_W'(FRAME_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [BAUD_W-1:0]     k_q, k_d;
  logic [BAUD_W-1:0]     cnt_q, cnt_d;
  logic [BITCNT_W-1:0]   bit_q, bit_d;
  logic [FRAME_W-1:0]    frame_d;
  logic                  ld_d, sh_d, done_d, rdy_d;
  logic                  wrap;

  // Frame word, LSB first: start, data, optional parity, stop fill of ones
  function automatic logic [FRAME_W-1:0] build_frame(
    input logic [7:0] d,
    input logic       e,
    input logic       p,
    input logic       odd
  );
    logic par8, par7;
    par8 = (^d) ^ odd;
    par7 = (^d[6:0]) ^ odd;
    case ({e, p})
      2'b11:   build_frame = {1'b1, par8, d, 1'b0};
      2'b10:   build_frame = {2'b11, d, 1'b0};
      2'b01:   build_frame = {2'b11, par7, d[6:0], 1'b0};
      default: build_frame = {3'b111, d[6:0], 1'b0};
    endcase
  endfunction

  // Next-state, counters, and lookahead of the registered outputs
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    frame_d = frame;
    wrap    = (cnt_q == (k_q - BAUD_W'(1)));

    case (state_q)
      IDLE: begin
        if (tx_start) begin
          frame_d = build_frame(tx_data, eight, pen, ohel);
          k_d     = (baud_k == '0) ? BAUD_W'(1) : baud_k;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        bit_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (wrap) begin
          cnt_d = '0;
          bit_d = bit_q + BITCNT_W'(1);
          if (bit_q == LAST_BIT) begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + BAUD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs describe the cycle being entered, so they can be registered
    ld_d   = (state_d == LOAD);
    rdy_d  = (state_d == IDLE);
    sh_d   = (state_d == SHIFT) && (cnt_d == (k_d - BAUD_W'(1)));
    done_d = sh_d && (bit_d == LAST_BIT);
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters, latched divisor and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_q    <= BAUD_W'(1);
      cnt_q  <= '0;
      bit_q  <= '0;
      frame  <= '1;
      ld     <= 1'b0;
      sh     <= 1'b0;
      done   <= 1'b0;
      tx_rdy <= 1'b1;
    end else begin
      k_q    <= k_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      frame  <= frame_d;
      ld     <= ld_d;
      sh     <= sh_d;
      done   <= done_d;
      tx_rdy <= rdy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with a modelled shift register and a
// scoreboard of expected frames and serial bits.
module tb_uart_tx_ctrl;

  localparam int unsigned BAUD_W = 20;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              tx_start = 1'b0;
  logic [7:0]        tx_data = 8'h00;
  logic              eight = 1'b1;
  logic              pen = 1'b0;
  logic              ohel = 1'b0;
  logic [BAUD_W-1:0] baud_k = BAUD_W'(1);
  logic              ld, sh, tx_rdy, done;
  logic [10:0]       frame;

  logic [10:0]       sr;
  logic              sdo;

  logic [10:0]       frame_q[$];
  logic              sdo_q[$];
  logic [10:0]       exp_frame;
  logic              exp_bit;

  int n_vec = 0;
  int n_err = 0;

  uart_tx_ctrl #(.BAUD_W(BAUD_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .eight    (eight),
    .pen      (pen),
    .ohel     (ohel),
    .baud_k   (baud_k),
    .ld       (ld),
    .sh       (sh),
    .frame    (frame),
    .tx_rdy   (tx_rdy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // External shift register, sdi tied to 1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sr <= '1;
    else if (ld) sr <= frame;
    else if (sh) sr <= {1'b1, sr[10:1]};
  end
  assign sdo = sr[0];

  function automatic logic [10:0] model_frame(input logic [7:0] d, input logic e,
                                              input logic p, input logic o);
    logic [10:0] f;
    logic        par;
    int          n;
    f   = '1;
    f[0] = 1'b0;
    n   = e ? 8 : 7;
    par = o;
    for (int i = 0; i < n; i++) begin
      f[1+i] = d[i];
      par    = par ^ d[i];
    end
    if (p) f[1+n] = par;
    return f;
  endfunction

  task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] ctl();
    return 11'({ld, sh, done, tx_rdy});
  endfunction

  // Drive one accepted start and check the load cycle (t0+1)
  task automatic start_frame(input logic [7:0] d, input logic e, input logic p,
                             input logic o, input logic [BAUD_W-1:0] k);
    logic [10:0] f;
    f = model_frame(d, e, p, o);
    frame_q.push_back(f);
    for (int i = 0; i < 11; i++) sdo_q.push_back(f[i]);
    tx_data  = d;
    eight    = e;
    pen      = p;
    ohel     = o;
    baud_k   = k;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    check("load_ctl", ctl(), 11'b1000);
    if (frame_q.size() == 0) begin
      check("frame_q_empty", 11'd1, 11'd0);
    end else begin
      exp_frame = frame_q.pop_front();
      check("frame", frame, exp_frame);
    end
  endtask

  // Walk cycles t0+2 .. t0+2+11K checking strobes and serial bits
  task automatic run_body(input int k, input bit poke);
    for (int c = 2; c <= 11 * k + 1; c++) begin
      @(negedge clk);
      check("shift_ctl", ctl(),
            11'({1'b0, ((c - 1) % k) == 0, c == 11 * k + 1, 1'b0}));
      if (sh) begin
        if (sdo_q.size() == 0) begin
          check("sdo_q_empty", 11'd1, 11'd0);
        end else begin
          exp_bit = sdo_q.pop_front();
          check("sdo", 11'(sdo), 11'(exp_bit));
        end
      end
      if (poke && c == 10) begin
        tx_start = 1'b1;
        tx_data  = 8'hFF;
        baud_k   = BAUD_W'(9);
      end
      if (poke && c == 11) tx_start = 1'b0;
    end
    @(negedge clk);
    check("end_ctl", ctl(), 11'b0001);
    check("frame_hold", frame, exp_frame);
    check("bits_left", 11'(sdo_q.size()), 11'd0);
  endtask

  initial begin
    int shc;

    // Reset held for 3 cycles
    repeat (3) @(negedge clk);
    check("rst_ctl", ctl(), 11'b0001);
    check("rst_frame", frame, 11'h7FF);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_ctl", ctl(), 11'b0001);
    check("post_rst_frame", frame, 11'h7FF);

    // 8N1, K=4, 0xA5
    start_frame(8'hA5, 1'b1, 1'b0, 1'b0, BAUD_W'(4));
    check("a5_frame_const", frame, 11'h74A);
    run_body(4, 1'b0);

    // 8-bit even / odd parity
    start_frame(8'h07, 1'b1, 1'b1, 1'b0, BAUD_W'(1));
    check("par8_even", 11'(frame[9]), 11'd1);
    run_body(1, 1'b0);
    start_frame(8'h07, 1'b1, 1'b1, 1'b1, BAUD_W'(2));
    check("par8_odd", 11'(frame[9]), 11'd0);
    run_body(2, 1'b0);

    // 7-bit even parity, bit 7 ignored
    start_frame(8'h83, 1'b0, 1'b1, 1'b0, BAUD_W'(3));
    check("par7_bit", 11'(frame[8]), 11'd0);
    check("par7_data", 11'(frame[7:1]), 11'h03);
    run_body(3, 1'b0);

    // 7N, K=2
    start_frame(8'h5A, 1'b0, 1'b0, 1'b0, BAUD_W'(2));
    run_body(2, 1'b0);

    // Busy start and divisor change mid-frame are ignored
    start_frame(8'h3C, 1'b1, 1'b0, 1'b0, BAUD_W'(4));
    run_body(4, 1'b1);
    @(negedge clk);
    check("busy_no_restart", ctl(), 11'b0001);

    // Degenerate divisor behaves as K=1
    start_frame(8'hC3, 1'b1, 1'b1, 1'b1, BAUD_W'(0));
    run_body(1, 1'b0);

    // Reset after the 5th shift
    start_frame(8'h96, 1'b1, 1'b1, 1'b0, BAUD_W'(2));
    shc = 0;
    for (int i = 0; i < 200 && shc < 5; i++) begin
      @(negedge clk);
      if (done) check("early_done", 11'd1, 11'd0);
      if (sh) begin
        shc++;
        exp_bit = sdo_q.pop_front();
        check("abort_sdo", 11'(sdo), 11'(exp_bit));
      end
    end
    check("abort_sh_count", 11'(shc), 11'd5);
    reset = 1'b0;
    #1;
    check("abort_ctl", ctl(), 11'b0001);
    check("abort_frame", frame, 11'h7FF);
    sdo_q.delete();
    repeat (3) begin
      @(negedge clk);
      check("abort_hold_ctl", ctl(), 11'b0001);
    end
    reset = 1'b1;
    @(negedge clk);
    check("abort_release_ctl", ctl(), 11'b0001);
    start_frame(8'h69, 1'b1, 1'b0, 1'b1, BAUD_W'(3));
    run_body(3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
